// File: rtl/systolic_mm_array.sv
// Output-stationary NxN systolic matrix-multiply engine: C = A*B with runtime K.
// Operands enter through per-row/column skew lines and results are read back one row at a time.
module systolic_mm_array #(
  parameter int unsigned N    = 4,
  parameter int unsigned DW   = 8,
  parameter int unsigned KW   = 8,
  parameter int unsigned ACCW = 2 * DW + KW,
  parameter int unsigned RW   = $clog2(N)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [KW-1:0]     k_len_i,
  input  logic              signed_mode_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [N*DW-1:0]   a_col_i,
  input  logic [N*DW-1:0]   b_row_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [RW-1:0]     out_row_o,
  output logic [N*ACCW-1:0] out_data_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned DCW = $clog2(2 * N);
  localparam logic [DCW-1:0] DrainLast = DCW'(2 * N - 2);

  typedef enum logic [1:0] {StIdle, StLoad, StDrain, StUnload} state_e;

  state_e        state_q;
  logic [KW-1:0] k_len_q, beat_q;
  logic          signed_q;
  logic [DCW-1:0] drain_q;
  logic [RW-1:0] out_row_q;
  logic          done_q;

  logic start_acc, beat_acc, acc_en;
  assign start_acc = (state_q == StIdle) && start_i;
  assign beat_acc  = (state_q == StLoad) && in_valid_i;
  assign acc_en    = (state_q == StLoad) || (state_q == StDrain);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      k_len_q   <= '0;
      signed_q  <= 1'b0;
      beat_q    <= '0;
      drain_q   <= '0;
      out_row_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            k_len_q  <= k_len_i;
            signed_q <= signed_mode_i;
            beat_q   <= '0;
            drain_q  <= '0;
            state_q  <= (k_len_i != '0) ? StLoad : StDrain;
          end
        end
        StLoad: begin
          if (in_valid_i) begin
            beat_q <= beat_q + 1'b1;
            if (beat_q + 1'b1 == k_len_q) state_q <= StDrain;
          end
        end
        StDrain: begin
          if (drain_q == DrainLast) begin
            drain_q   <= '0;
            out_row_q <= '0;
            state_q   <= StUnload;
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        StUnload: begin
          if (out_ready_i) begin
            if (out_row_q == RW'(N - 1)) begin
              out_row_q <= '0;
              done_q    <= 1'b1;
              state_q   <= StIdle;
            end else begin
              out_row_q <= out_row_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready_o  = (state_q == StLoad);
  assign out_valid_o = (state_q == StUnload);
  assign busy_o      = (state_q != StIdle);
  assign out_row_o   = out_row_q;
  assign done_o      = done_q;

  // Bubbles and non-LOAD cycles inject zeros on every feeder at once, keeping alignment.
  logic [DW-1:0] a_inj [N];
  logic [DW-1:0] b_inj [N];
  logic [DW-1:0] a_skew [N];
  logic [DW-1:0] b_skew [N];

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      a_inj[i] = beat_acc ? a_col_i[i*DW +: DW] : '0;
      b_inj[i] = beat_acc ? b_row_i[i*DW +: DW] : '0;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign a_skew[i] = a_inj[i];
      assign b_skew[i] = b_inj[i];
    end else begin : g_dly
      logic [DW-1:0] a_dly_q [i];
      logic [DW-1:0] b_dly_q [i];
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          for (int k = 0; k < i; k++) begin
            a_dly_q[k] <= '0;
            b_dly_q[k] <= '0;
          end
        end else begin
          a_dly_q[0] <= a_inj[i];
          b_dly_q[0] <= b_inj[i];
          for (int k = 1; k < i; k++) begin
            a_dly_q[k] <= a_dly_q[k-1];
            b_dly_q[k] <= b_dly_q[k-1];
          end
        end
      end
      assign a_skew[i] = a_dly_q[i-1];
      assign b_skew[i] = b_dly_q[i-1];
    end
  end

  logic [DW-1:0]   a_out [N][N];
  logic [DW-1:0]   b_out [N][N];
  logic [ACCW-1:0] acc   [N][N];

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_pe
      logic [DW-1:0]          a_op, b_op, a_q, b_q;
      logic [ACCW-1:0]        acc_q, prod_ext;
      logic signed [DW:0]     a_ext, b_ext;
      logic signed [2*DW+1:0] a_w, b_w, prod;

      if (j == 0) begin : g_a_edge
        assign a_op = a_skew[i];
      end else begin : g_a_int
        assign a_op = a_out[i][j-1];
      end
      if (i == 0) begin : g_b_edge
        assign b_op = b_skew[j];
      end else begin : g_b_int
        assign b_op = b_out[i-1][j];
      end

      // One extra bit turns both modes into a single signed multiply.
      assign a_ext    = {signed_q & a_op[DW-1], a_op};
      assign b_ext    = {signed_q & b_op[DW-1], b_op};
      assign a_w      = {{(DW + 1){a_ext[DW]}}, a_ext};
      assign b_w      = {{(DW + 1){b_ext[DW]}}, b_ext};
      assign prod     = a_w * b_w;
      assign prod_ext = {{(ACCW - 2 * DW - 2){prod[2*DW+1]}}, prod};

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          a_q   <= '0;
          b_q   <= '0;
          acc_q <= '0;
        end else if (start_acc) begin
          a_q   <= '0;
          b_q   <= '0;
          acc_q <= '0;
        end else begin
          a_q <= a_op;
          b_q <= b_op;
          if (acc_en) acc_q <= acc_q + prod_ext;
        end
      end

      assign a_out[i][j] = a_q;
      assign b_out[i][j] = b_q;
      assign acc[i][j]   = acc_q;
    end
  end

  always_comb begin
    out_data_o = '0;
    for (int unsigned j = 0; j < N; j++) begin
      out_data_o[j*ACCW +: ACCW] = acc[out_row_q][j];
    end
  end

endmodule

// File: tb/tb_systolic_mm_array.sv
// Directed bench for systolic_mm_array (N=4, DW=8): identity, signed, bubbles,
// backpressure, max magnitude, K=0 with back-to-back start, and async reset mid-job.
module tb_systolic_mm_array;
  localparam int N = 4, DW = 8, KW = 8, ACCW = 24, RW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            start = 1'b0;
  logic [KW-1:0]   k_len = '0;
  logic            signed_mode = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [N*DW-1:0] a_col = '0;
  logic [N*DW-1:0] b_row = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [RW-1:0]   out_row;
  logic [N*ACCW-1:0] out_data;
  logic            busy;
  logic            done;

  systolic_mm_array #(.N(N), .DW(DW), .KW(KW), .ACCW(ACCW), .RW(RW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .k_len_i      (k_len),
    .signed_mode_i(signed_mode),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .a_col_i      (a_col),
    .b_row_i      (b_row),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_row_o    (out_row),
    .out_data_o   (out_data),
    .busy_o       (busy),
    .done_o       (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [ACCW-1:0] exp_c [N][N];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] a, input logic [31:0] b, input logic v);
    a_col    = a;
    b_row    = b;
    in_valid = v;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic start_job(input logic [KW-1:0] k, input logic s);
    start       = 1'b1;
    k_len       = k;
    signed_mode = s;
    tick();
    start = 1'b0;
  endtask

  function automatic logic [31:0] a_ident(input int k);
    logic [31:0] v = '0;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = (i == k) ? 8'd1 : 8'd0;
    return v;
  endfunction

  function automatic logic [31:0] b_ident(input int k);
    logic [31:0] v = '0;
    for (int j = 0; j < N; j++) v[j*DW +: DW] = 8'(4 * k + j + 1);
    return v;
  endfunction

  task automatic set_exp_ident();
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++) exp_c[r][j] = ACCW'(4 * r + j + 1);
  endtask

  task automatic set_exp_const(input logic [ACCW-1:0] v);
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++) exp_c[r][j] = v;
  endtask

  // Reads all rows against exp_c; returns in the cycle where done must be high.
  task automatic read_rows(input string tag, input int stall_row);
    int w = 0;
    while (!out_valid && w < 600) begin
      tick();
      w++;
    end
    check($sformatf("%s out_valid seen", tag), 128'(out_valid), 128'(1));
    out_ready = 1'b1;
    for (int r = 0; r < N; r++) begin
      if (r == stall_row) begin
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          check($sformatf("%s stall%0d row", tag, s), 128'(out_row), 128'(r));
          check($sformatf("%s stall%0d valid", tag, s), 128'(out_valid), 128'(1));
          for (int j = 0; j < N; j++)
            check($sformatf("%s stall%0d c%0d", tag, s, j),
                  128'(out_data[j*ACCW +: ACCW]), 128'(exp_c[r][j]));
          tick();
        end
        out_ready = 1'b1;
      end
      check($sformatf("%s row%0d idx", tag, r), 128'(out_row), 128'(r));
      check($sformatf("%s row%0d valid", tag, r), 128'(out_valid), 128'(1));
      for (int j = 0; j < N; j++)
        check($sformatf("%s r%0d c%0d", tag, r, j),
              128'(out_data[j*ACCW +: ACCW]), 128'(exp_c[r][j]));
      check($sformatf("%s r%0d no early done", tag, r), 128'(done), 128'(0));
      tick();
    end
    out_ready = 1'b0;
    check($sformatf("%s done", tag), 128'(done), 128'(1));
    check($sformatf("%s valid low", tag), 128'(out_valid), 128'(0));
    check($sformatf("%s busy low", tag), 128'(busy), 128'(0));
  endtask

  initial begin
    int cyc;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst in_ready", 128'(in_ready), 128'(0));
    check("rst out_valid", 128'(out_valid), 128'(0));
    check("rst busy", 128'(busy), 128'(0));
    check("rst done", 128'(done), 128'(0));
    check("rst out_row", 128'(out_row), 128'(0));
    check("rst out_data", 128'(out_data), 128'(0));
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Identity with latency measurement
    set_exp_ident();
    cyc = 0;
    start_job(8'd4, 1'b0);
    cyc++;
    check("id busy", 128'(busy), 128'(1));
    check("id in_ready", 128'(in_ready), 128'(1));
    for (int k = 0; k < 4; k++) begin
      beat(a_ident(k), b_ident(k), 1'b1);
      cyc++;
    end
    check("id in_ready drop", 128'(in_ready), 128'(0));
    while (!out_valid && cyc < 100) begin
      tick();
      cyc++;
    end
    check("id latency", 128'(cyc), 128'(12));
    read_rows("id", -1);
    tick();
    check("id done pulse end", 128'(done), 128'(0));

    // Signed with bubbles; garbage on bubble cycles must be ignored
    set_exp_const(24'hFFFFFA);
    start_job(8'd3, 1'b1);
    beat(32'hFFFFFFFF, 32'h02020202, 1'b1);
    beat(32'h55555555, 32'h77777777, 1'b0);
    beat(32'hFFFFFFFF, 32'h02020202, 1'b1);
    beat(32'h55555555, 32'h77777777, 1'b0);
    beat(32'hFFFFFFFF, 32'h02020202, 1'b1);
    read_rows("sgn_bub", -1);
    tick();

    // Same job without bubbles
    start_job(8'd3, 1'b1);
    for (int k = 0; k < 3; k++) beat(32'hFFFFFFFF, 32'h02020202, 1'b1);
    read_rows("sgn", -1);
    tick();

    // Backpressure on row 1, single done pulse
    set_exp_ident();
    start_job(8'd4, 1'b0);
    for (int k = 0; k < 4; k++) beat(a_ident(k), b_ident(k), 1'b1);
    read_rows("bp", 1);
    tick();
    check("bp done once", 128'(done), 128'(0));
    tick();
    check("bp done stays low", 128'(done), 128'(0));

    // Max magnitude, unsigned
    set_exp_const(24'd16581375);
    start_job(8'd255, 1'b0);
    for (int k = 0; k < 255; k++) beat(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    read_rows("max", -1);
    tick();

    // K=0 job, then a new start in the done cycle
    set_exp_const(24'd0);
    start_job(8'd0, 1'b0);
    check("k0 busy", 128'(busy), 128'(1));
    check("k0 in_ready", 128'(in_ready), 128'(0));
    read_rows("k0", -1);
    start_job(8'd2, 1'b0);
    check("b2b accepted", 128'(in_ready), 128'(1));
    check("b2b done fell", 128'(done), 128'(0));
    // A[i][k] = i+k+1, B[k][j] = (k+1)(j+1)  =>  C[i][j] = (j+1)(3i+5)
    for (int k = 0; k < 2; k++) begin
      logic [31:0] a, b;
      for (int i = 0; i < N; i++) begin
        a[i*DW +: DW] = 8'(i + k + 1);
        b[i*DW +: DW] = 8'((k + 1) * (i + 1));
      end
      beat(a, b, 1'b1);
    end
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++) exp_c[r][j] = ACCW'((j + 1) * (3 * r + 5));
    read_rows("b2b", -1);
    tick();

    // Async reset mid-LOAD
    start_job(8'd4, 1'b0);
    beat(a_ident(0), b_ident(0), 1'b1);
    beat(a_ident(1), b_ident(1), 1'b1);
    #3 rst_n = 1'b0;
    #1;
    check("arst busy", 128'(busy), 128'(0));
    check("arst in_ready", 128'(in_ready), 128'(0));
    check("arst out_valid", 128'(out_valid), 128'(0));
    check("arst out_data", 128'(out_data), 128'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    check("arst no done", 128'(done), 128'(0));
    set_exp_ident();
    start_job(8'd4, 1'b0);
    for (int k = 0; k < 4; k++) beat(a_ident(k), b_ident(k), 1'b1);
    read_rows("post_rst", -1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
